lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
// - Load/store initiator between the MEM stage and data_ram: accepts one load/store request, drives
//   data_ram ce/raddr/waddr/data_i/sel/r_ena/w_ena, returns aligned, sign/zero-extended load data.
// - Byte-lane placement for B/H/W/D; optional two-beat split for accesses crossing an 8-byte line.
// PARAMETERS
// - ADDR_W   64   address width (ram_raddr/ram_waddr width = `REGBUS)
// - DATA_W   64   data width; fixed at 64 (8 byte lanes)
// PORTS
// - clk          in   1       clock; all state on posedge
// - rst_n        in   1       asynchronous, active-low reset
// - req_valid    in   1       MEM stage presents a request
// - req_ready    out  1       block can accept (high only in IDLE)
// - req_we       in   1       1 = store, 0 = load
// - req_size     in   2       00 B, 01 H, 10 W, 11 D
// - req_unsigned in   1       load zero-extends when 1, sign-extends when 0
// - req_addr     in   ADDR_W  byte address
// - req_wdata    in   64      store data, LSB-aligned
// - rsp_valid    out  1       one-cycle pulse: access complete
// - rsp_rdata    out  64      extended load data (0 for stores)
// - rsp_err      out  1       misaligned-crossing error (see CONFIGURATION)
// - ram_ce, ram_r_ena, ram_w_ena  out 1 each;  ram_raddr, ram_waddr out ADDR_W;  ram_wdata out 64;  ram_sel out 8
// - ram_rdata    in   64      data_ram read data (combinational in raddr)
// BEHAVIOUR
// - Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; all ram_* outputs 0; req_ready=1.
// - FSM: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE. Request latched on req_valid&&req_ready in IDLE.
// - off=addr[2:0], nb=1<<size, mask=(2^nb-1)<<off (16 bits), wsh=wdata<<(8*off) (128 bits).
// - cross = off+nb > 8. Line address = addr with [2:0] cleared; beat1 address = line+8.
// - ACC0: ram_ce=1; raddr=waddr=line; sel=mask[7:0]; wdata=wsh[63:0]; w_ena=we; r_ena=!we.
//   Load captures ram_rdata into lo register at end of cycle.
// - ACC1 (cross only): same with line+8, sel=mask[15:8], wdata=wsh[127:64]; load captures hi.
// - RESP: ram_* all 0; rsp_valid=1; rsp_rdata=({hi,lo}>>(8*off)) truncated to nb bytes, extended.
// - Latency: accept at edge N -> rsp_valid in cycle N+2 (single beat), N+3 (split).
// - req_ready=0 in ACC0/ACC1/RESP; next request may be accepted in the cycle after RESP.
// - Stores: rsp_rdata=0. No response backpressure; MEM stage must take rsp_valid when pulsed.
// - Async reset mid-access: immediate return to IDLE, ram_* deasserted; a beat-0 store already
//   clocked into data_ram stays written (no rollback).
// CONFIGURATION
// - LSU_MISALIGN_SPLIT_EN defined: cross accesses split into ACC0+ACC1 as above; rsp_err always 0.
// - Not defined: cross accesses skip ACC0/ACC1 entirely (no ram_ce/w_ena), go to RESP with
//   rsp_err=1, rsp_rdata=0, latency N+2. Non-crossing unaligned accesses always served in one beat.
// STRUCTURE
// - define.v: size encodings (SIZE_B/H/W/D), FSM state encodings, `ZERO_64, `REGBUS.
// - Sub-module mem_lane_align (combinational): mask/shift for stores, shift/extend for loads.
// TESTING
// - SD 0x10, 0x1122334455667788 -> ACC0 waddr 0x10, sel 0xFF, w_ena=1; LD 0x10 -> rsp_rdata same, N+2.
// - LB 0x10 -> 0xFFFFFFFFFFFFFF88; LBU 0x10 -> 0x0000000000000088; LH 0x12 -> 0x0000000000005566.
// - SH 0x16, 0xBEEF -> sel 0xC0, ram_wdata[63:48]=0xBEEF, single beat, rsp_valid N+2.
// - SW 0x1E, 0xDEADBEEF with macro: beat0 waddr 0x18 sel 0xC0; beat1 waddr 0x20 sel 0x03,
//   wdata[15:0]=0xDEAD; LW 0x1E -> 0xFFFFFFFFDEADBEEF at N+3. Without macro: rsp_err=1, no w_ena.
// - rst_n low during ACC1 -> ram_w_ena/ram_ce 0 same cycle, rsp_valid never pulses, req_ready=1.
// - req_valid held high for 3 loads -> req_ready low while busy; exactly 3 rsp_valid pulses, in order.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : lsu_mem_ctrl_pkg                                              |
// | Purpose  : Shared encodings for the load/store memory controller:        |
// |            access-size codes, FSM state codes, and size helper functions.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package lsu_mem_ctrl_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // Controller FSM encodings
  localparam int unsigned   STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACC0 = 2'd1;
  localparam logic [STATE_W-1:0] ST_ACC1 = 2'd2;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd3;

  localparam logic [63:0] ZERO_64 = 64'h0;

  // Number of bytes touched by an access of the given size (1/2/4/8)
  function automatic logic [3:0] size_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // LSB-aligned byte-enable pattern for an access of the given size
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_ctrl_mem_lane_align.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : lsu_mem_ctrl_mem_lane_align                                   |
// | Purpose  : Combinational byte-lane steering. Builds the 16-bit byte      |
// |            enable and 128-bit shifted store data spanning two 8-byte     |
// |            lines, flags line-crossing accesses, and right-aligns and     |
// |            sign/zero-extends load data gathered from {hi,lo} lines.      |
// | Ports    : off_i      byte offset within the line                        |
// |            size_i     access size code                                   |
// |            unsigned_i 1 = zero-extend loads                              |
// |            wdata_i    LSB-aligned store data                             |
// |            lo_i/hi_i  read data of beat 0 / beat 1                       |
// |            mask_o     byte enables for {beat1, beat0}                    |
// |            wsh_o      store data for {beat1, beat0}                      |
// |            rdata_o    extended load result                               |
// |            cross_o    access spills past the end of the 8-byte line      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_ctrl_mem_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]   off_i,
  input  logic [1:0]   size_i,
  input  logic         unsigned_i,
  input  logic [63:0]  wdata_i,
  input  logic [63:0]  lo_i,
  input  logic [63:0]  hi_i,
  output logic [15:0]  mask_o,
  output logic [127:0] wsh_o,
  output logic [63:0]  rdata_o,
  output logic         cross_o
);

  logic [5:0]  w_bit_sh;
  logic [3:0]  w_end;
  logic [63:0] w_rsh;
  logic        w_ext;

  assign w_bit_sh = {off_i, 3'b000};

  always_comb begin
    mask_o  = {8'h00, size_mask(size_i)} << off_i;
    wsh_o   = {64'h0, wdata_i} << w_bit_sh;
    // End offset (exclusive) reaches at most 7+8 = 15, fits in 4 bits
    w_end   = {1'b0, off_i} + size_nbytes(size_i);
    cross_o = (w_end > 4'd8);
    // Only the low 64 bits of the shifted pair can hold the loaded value
    w_rsh   = 64'({hi_i, lo_i} >> w_bit_sh);
    w_ext   = 1'b0;
    case (size_i)
      SIZE_B: begin
        w_ext   = ~unsigned_i & w_rsh[7];
        rdata_o = {{56{w_ext}}, w_rsh[7:0]};
      end
      SIZE_H: begin
        w_ext   = ~unsigned_i & w_rsh[15];
        rdata_o = {{48{w_ext}}, w_rsh[15:0]};
      end
      SIZE_W: begin
        w_ext   = ~unsigned_i & w_rsh[31];
        rdata_o = {{32{w_ext}}, w_rsh[31:0]};
      end
      default: rdata_o = w_rsh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : lsu_mem_ctrl                                                  |
// | Purpose  : Load/store initiator between the MEM stage and data_ram.      |
// |            Accepts one request at a time, drives the RAM for one or two |
// |            beats, and returns aligned, extended load data.              |
// | Config   : LSU_MISALIGN_SPLIT_EN - when defined, line-crossing accesses |
// |            are split into two beats; otherwise they are rejected with   |
// |            rsp_err and never touch the RAM.                              |
// | Ports    : clk, rst_n (async, active low)                                |
// |            req_*  request handshake and payload from the MEM stage       |
// |            rsp_*  single-cycle completion pulse, load data, error        |
// |            ram_*  data_ram control/address/data, ram_rdata is comb       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_ce,
  output logic              ram_r_ena,
  output logic              ram_w_ena,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [7:0]        ram_sel,
  input  logic [DATA_W-1:0] ram_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic C_SPLIT_EN = 1'b1;
`else
  localparam logic C_SPLIT_EN = 1'b0;
`endif

  logic [STATE_W-1:0] state_q, state_d;
  logic               we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  lo_q;
  logic [DATA_W-1:0]  hi_q;

  logic [15:0]        w_mask;
  logic [127:0]       w_wsh;
  logic [63:0]        w_rdata;
  logic               w_cross;
  logic               w_split;
  logic               w_err;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_line;
  logic [ADDR_W-1:0]  w_line_nxt;

  // All steering works from the latched request so RAM outputs are stable
  lsu_mem_ctrl_mem_lane_align u_align (
    .off_i      (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .lo_i       (lo_q),
    .hi_i       (hi_q),
    .mask_o     (w_mask),
    .wsh_o      (w_wsh),
    .rdata_o    (w_rdata),
    .cross_o    (w_cross)
  );

  assign w_split    = C_SPLIT_EN & w_cross;
  // Without splitting, a crossing access is rejected: no RAM beat, error response
  assign w_err      = ~C_SPLIT_EN & w_cross;
  assign w_accept   = req_valid & req_ready;
  assign w_line     = {addr_q[ADDR_W-1:3], 3'b000};
  assign w_line_nxt = w_line + {{(ADDR_W-4){1'b0}}, 4'd8};

  // State and request/data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        hi_q    <= '0;
      end
      if (state_q == ST_ACC0 && !we_q) lo_q <= ram_rdata;
      if (state_q == ST_ACC1 && !we_q) hi_q <= ram_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_ACC0;
      ST_ACC0: state_d = w_split ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = ZERO_64;
    rsp_err   = 1'b0;
    ram_ce    = 1'b0;
    ram_r_ena = 1'b0;
    ram_w_ena = 1'b0;
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_sel   = 8'h00;
    case (state_q)
      ST_ACC0: begin
        // A rejected crossing access passes through ACC0 silently to keep latency fixed
        if (!w_err) begin
          ram_ce    = 1'b1;
          ram_raddr = w_line;
          ram_waddr = w_line;
          ram_sel   = w_mask[7:0];
          ram_wdata = w_wsh[63:0];
          ram_w_ena = we_q;
          ram_r_ena = ~we_q;
        end
      end
      ST_ACC1: begin
        ram_ce    = 1'b1;
        ram_raddr = w_line_nxt;
        ram_waddr = w_line_nxt;
        ram_sel   = w_mask[15:8];
        ram_wdata = w_wsh[127:64];
        ram_w_ena = we_q;
        ram_r_ena = ~we_q;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = w_err;
        if (!we_q && !w_err) rsp_rdata = w_rdata;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_lsu_mem_ctrl                                               |
// | Purpose  : Self-checking bench for lsu_mem_ctrl with a small byte-lane   |
// |            RAM model. Expectations follow LSU_MISALIGN_SPLIT_EN.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_ce, ram_r_ena, ram_w_ena;
  logic [63:0] ram_raddr, ram_waddr, ram_wdata;
  logic [7:0]  ram_sel;
  logic [63:0] ram_rdata;

  lsu_mem_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_ce       (ram_ce),
    .ram_r_ena    (ram_r_ena),
    .ram_w_ena    (ram_w_ena),
    .ram_raddr    (ram_raddr),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_sel      (ram_sel),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: 16 words, byte-enabled writes, combinational read
  logic [63:0] mem [0:15];
  logic        mem_clr = 1'b1;
  assign ram_rdata = mem[ram_raddr[6:3]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (ram_ce && ram_w_ena) begin
      for (int b = 0; b < 8; b++)
        if (ram_sel[b]) mem[ram_waddr[6:3]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    logic        split;
    logic        ce0;
    logic [7:0]  sel0;
    logic [63:0] addr0;
    logic [63:0] wd0;
    logic [7:0]  sel1;
    logic [63:0] addr1;
    logic [63:0] wd1;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input logic err, input logic split,
                              input logic ce0, input logic [7:0] sel0, input logic [63:0] addr0,
                              input logic [63:0] wd0, input logic [7:0] sel1,
                              input logic [63:0] addr1, input logic [63:0] wd1);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.split = split; v.ce0 = ce0; v.sel0 = sel0;
    v.addr0 = addr0; v.wd0 = wd0; v.sel1 = sel1; v.addr1 = addr1; v.wd1 = wd1;
    return v;
  endfunction

  // Rejected crossing access: no RAM beat, error, zero data
  function automatic vec_t mk_err(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [63:0] addr, input logic [63:0] wdata);
    return mk(we, size, uns, addr, wdata, 64'h0, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0,
              8'h00, 64'h0, 64'h0);
  endfunction

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk($sformatf("v%0d b0 ce", i), 64'(ram_ce), 64'(v.ce0));
    chk($sformatf("v%0d b0 sel", i), 64'(ram_sel), 64'(v.sel0));
    chk($sformatf("v%0d b0 raddr", i), ram_raddr, v.addr0);
    chk($sformatf("v%0d b0 waddr", i), ram_waddr, v.addr0);
    chk($sformatf("v%0d b0 wdata", i), ram_wdata, v.wd0);
    chk($sformatf("v%0d b0 w_ena", i), 64'(ram_w_ena), 64'(v.ce0 & v.we));
    chk($sformatf("v%0d b0 r_ena", i), 64'(ram_r_ena), 64'(v.ce0 & ~v.we));
    chk($sformatf("v%0d b0 ready", i), 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    if (v.split) begin
      chk($sformatf("v%0d b1 ce", i), 64'(ram_ce), 64'(1));
      chk($sformatf("v%0d b1 sel", i), 64'(ram_sel), 64'(v.sel1));
      chk($sformatf("v%0d b1 addr", i), v.we ? ram_waddr : ram_raddr, v.addr1);
      chk($sformatf("v%0d b1 wdata", i), ram_wdata, v.wd1);
      chk($sformatf("v%0d b1 w_ena", i), 64'(ram_w_ena), 64'(v.we));
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'(1));
    chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, v.rdata);
    chk($sformatf("v%0d rsp_err", i), 64'(rsp_err), 64'(v.err));
    chk($sformatf("v%0d resp ce", i), 64'(ram_ce), 64'(0));
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp_valid drop", i), 64'(rsp_valid), 64'(0));
    chk($sformatf("v%0d ready back", i), 64'(req_ready), 64'(1));
  endtask

  task automatic set_load(input int k);
    req_we = 1'b0;
    case (k)
      0: begin req_size = 2'b11; req_unsigned = 1'b0; req_addr = 64'h10; end
      1: begin req_size = 2'b00; req_unsigned = 1'b1; req_addr = 64'h10; end
      default: begin req_size = 2'b01; req_unsigned = 1'b1; req_addr = 64'h16; end
    endcase
    req_wdata = '0;
  endtask

  initial begin
    logic [63:0] exp_b2b [3];
    logic [63:0] got_q [$];
    int          k;
    int          pulses;
    bit          pend;

    // Single-beat vectors
    vecs[0]  = mk(1, 2'b11, 0, 64'h10, 64'h1122334455667788, 64'h0, 0, 0, 1, 8'hFF, 64'h10,
                  64'h1122334455667788, 8'h00, 64'h0, 64'h0);
    vecs[1]  = mk(0, 2'b11, 0, 64'h10, 64'h0, 64'h1122334455667788, 0, 0, 1, 8'hFF, 64'h10,
                  64'h0, 8'h00, 64'h0, 64'h0);
    vecs[2]  = mk(0, 2'b00, 0, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, 0, 1, 8'h01, 64'h10,
                  64'h0, 8'h00, 64'h0, 64'h0);
    vecs[3]  = mk(0, 2'b00, 1, 64'h10, 64'h0, 64'h0000000000000088, 0, 0, 1, 8'h01, 64'h10,
                  64'h0, 8'h00, 64'h0, 64'h0);
    vecs[4]  = mk(0, 2'b01, 0, 64'h12, 64'h0, 64'h0000000000005566, 0, 0, 1, 8'h0C, 64'h10,
                  64'h0, 8'h00, 64'h0, 64'h0);
    vecs[5]  = mk(1, 2'b01, 0, 64'h16, 64'hBEEF, 64'h0, 0, 0, 1, 8'hC0, 64'h10,
                  64'hBEEF000000000000, 8'h00, 64'h0, 64'h0);
    vecs[6]  = mk(0, 2'b10, 0, 64'h14, 64'h0, 64'hFFFFFFFFBEEF3344, 0, 0, 1, 8'hF0, 64'h10,
                  64'h0, 8'h00, 64'h0, 64'h0);
    vecs[7]  = mk(0, 2'b10, 1, 64'h14, 64'h0, 64'h00000000BEEF3344, 0, 0, 1, 8'hF0, 64'h10,
                  64'h0, 8'h00, 64'h0, 64'h0);
    vecs[8]  = mk(0, 2'b01, 1, 64'h16, 64'h0, 64'h000000000000BEEF, 0, 0, 1, 8'hC0, 64'h10,
                  64'h0, 8'h00, 64'h0, 64'h0);
    // Line-crossing vectors and the byte at the very end of a line
    if (SPLIT) begin
      vecs[9]  = mk(1, 2'b10, 0, 64'h1E, 64'hDEADBEEF, 64'h0, 0, 1, 1, 8'hC0, 64'h18,
                    64'hBEEF000000000000, 8'h03, 64'h20, 64'h000000000000DEAD);
      vecs[10] = mk(0, 2'b10, 0, 64'h1E, 64'h0, 64'hFFFFFFFFDEADBEEF, 0, 1, 1, 8'hC0, 64'h18,
                    64'h0, 8'h03, 64'h20, 64'h0);
      vecs[11] = mk(0, 2'b00, 0, 64'h1F, 64'h0, 64'hFFFFFFFFFFFFFFBE, 0, 0, 1, 8'h80, 64'h18,
                    64'h0, 8'h00, 64'h0, 64'h0);
      vecs[12] = mk(0, 2'b11, 0, 64'h11, 64'h0, 64'h00BEEF3344556677, 0, 1, 1, 8'hFE, 64'h10,
                    64'h0, 8'h01, 64'h18, 64'h0);
      vecs[13] = mk(0, 2'b01, 0, 64'h17, 64'h0, 64'h00000000000000BE, 0, 1, 1, 8'h80, 64'h10,
                    64'h0, 8'h01, 64'h18, 64'h0);
    end else begin
      vecs[9]  = mk_err(1, 2'b10, 0, 64'h1E, 64'hDEADBEEF);
      vecs[10] = mk_err(0, 2'b10, 0, 64'h1E, 64'h0);
      vecs[11] = mk(0, 2'b00, 0, 64'h1F, 64'h0, 64'h0, 0, 0, 1, 8'h80, 64'h18,
                    64'h0, 8'h00, 64'h0, 64'h0);
      vecs[12] = mk_err(0, 2'b11, 0, 64'h11, 64'h0);
      vecs[13] = mk_err(0, 2'b01, 0, 64'h17, 64'h0);
    end

    // Reset state
    repeat (2) @(posedge clk);
    mem_clr = 1'b0;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'(1));
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset rsp_rdata", rsp_rdata, 64'h0);
    chk("reset rsp_err", 64'(rsp_err), 64'(0));
    chk("reset ram_ce", 64'(ram_ce), 64'(0));
    chk("reset ram_w_ena", 64'(ram_w_ena), 64'(0));
    chk("reset ram_r_ena", 64'(ram_r_ena), 64'(0));
    chk("reset ram_sel", 64'(ram_sel), 64'(0));
    chk("reset ram_waddr", ram_waddr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Asynchronous reset in the last RAM beat of a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_unsigned = 1'b0;
    if (SPLIT) begin
      req_size = 2'b10; req_addr = 64'h1E; req_wdata = 64'hDEADBEEF;
    end else begin
      req_size = 2'b00; req_addr = 64'h10; req_wdata = 64'h88;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (SPLIT) begin
      @(posedge clk); #1;
    end
    chk("rst mid-access ce before", 64'(ram_ce), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst mid-access ce", 64'(ram_ce), 64'(0));
    chk("rst mid-access w_ena", 64'(ram_w_ena), 64'(0));
    chk("rst mid-access ready", 64'(req_ready), 64'(1));
    chk("rst mid-access rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("rst mid-access no rsp", 64'(pulses), 64'(0));

    // Three loads with req_valid held high throughout
    exp_b2b[0] = 64'hBEEF334455667788;
    exp_b2b[1] = 64'h0000000000000088;
    exp_b2b[2] = 64'h000000000000BEEF;
    k = 0;
    pend = 1'b0;
    @(negedge clk);
    set_load(0);
    req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) got_q.push_back(rsp_rdata);
      if (pend) begin
        chk($sformatf("b2b busy ready %0d", k), 64'(req_ready), 64'(0));
        pend = 1'b0;
        k++;
        if (k < 3) set_load(k);
        else req_valid = 1'b0;
      end
      if (req_valid && req_ready) pend = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b rsp count", 64'(got_q.size()), 64'(3));
    for (int j = 0; j < 3; j++) begin
      if (j < got_q.size()) chk($sformatf("b2b rdata %0d", j), got_q[j], exp_b2b[j]);
      else chk($sformatf("b2b rdata %0d missing", j), 64'hX, exp_b2b[j]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
